// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: issue and result-capture stage for the bi-directional
// shifter. Accepts shift requests over valid/ready, drives the shifter
// controls for one or two passes, captures SH_Z and presents the result
// downstream over a second valid/ready handshake.
// Optional feature macro: SHIFT_ROTATE_EN (two-pass ROL/ROR support).
// Without it, ROL/ROR are reported as illegal opcodes.
module shift_issue_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IN_OP,
    input  logic [31:0]      IN_X,
    input  logic [4:0]       IN_S,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic [31:0]      SH_X,
    output logic [4:0]       SH_S,
    output logic             SH_LEFT,
    output logic             SH_LOG,
    output logic             SH_EN,
    input  logic [31:0]      SH_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_Z,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ERR
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [TAG_W-1:0] tag_r;
    logic             accept_s;
`ifdef SHIFT_ROTATE_EN
    logic             rot_r;
    logic [31:0]      partial_r;
`endif

    // Opcodes this build can execute on the shifter.
    function automatic logic op_supported(input logic [2:0] op);
        logic ok;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROL, OP_ROR:         ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A new request can enter when idle or when the held result leaves this cycle.
    always_comb begin
        IN_READY = (state_r == ST_IDLE) || ((state_r == ST_DONE) && OUT_READY);
        accept_s = IN_VALID && IN_READY;
    end

    // Sequencer: state, shifter controls and result register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            tag_r     <= {TAG_W{1'b0}};
            SH_X      <= 32'd0;
            SH_S      <= 5'd0;
            SH_LEFT   <= 1'b0;
            SH_LOG    <= 1'b0;
            SH_EN     <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_Z     <= 32'd0;
            OUT_TAG   <= {TAG_W{1'b0}};
            OUT_ERR   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_r     <= 1'b0;
            partial_r <= 32'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (op_supported(IN_OP)) begin
                            // First pass: left for SLL/ROL, arithmetic only for SRA.
                            state_r   <= ST_EXEC1;
                            tag_r     <= IN_TAG;
                            SH_EN     <= 1'b1;
                            SH_X      <= IN_X;
                            SH_S      <= IN_S;
                            SH_LEFT   <= (IN_OP == OP_SLL) || (IN_OP == OP_ROL);
                            SH_LOG    <= (IN_OP != OP_SRA);
                            OUT_VALID <= 1'b0;
`ifdef SHIFT_ROTATE_EN
                            rot_r     <= (IN_OP == OP_ROL) || (IN_OP == OP_ROR);
`endif
                        end else begin
                            // Illegal opcodes skip the shifter entirely.
                            state_r   <= ST_DONE;
                            OUT_VALID <= 1'b1;
                            OUT_Z     <= 32'd0;
                            OUT_ERR   <= 1'b1;
                            OUT_TAG   <= IN_TAG;
                        end
                    end else if ((state_r == ST_DONE) && OUT_READY) begin
                        state_r   <= ST_IDLE;
                        OUT_VALID <= 1'b0;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                ST_EXEC1: begin
`ifdef SHIFT_ROTATE_EN
                    if (rot_r && (SH_S != 5'd0)) begin
                        // Rotate: keep the first pass, then shift the other way by 32-n.
                        state_r   <= ST_EXEC2;
                        partial_r <= SH_Z;
                        SH_LEFT   <= ~SH_LEFT;
                        SH_LOG    <= 1'b1;
                        SH_S      <= 5'd0 - SH_S;
                    end else begin
                        state_r   <= ST_DONE;
                        SH_EN     <= 1'b0;
                        OUT_VALID <= 1'b1;
                        OUT_Z     <= SH_Z;
                        OUT_ERR   <= 1'b0;
                        OUT_TAG   <= tag_r;
                    end
`else
                    state_r   <= ST_DONE;
                    SH_EN     <= 1'b0;
                    OUT_VALID <= 1'b1;
                    OUT_Z     <= SH_Z;
                    OUT_ERR   <= 1'b0;
                    OUT_TAG   <= tag_r;
`endif
                end
`ifdef SHIFT_ROTATE_EN
                ST_EXEC2: begin
                    state_r   <= ST_DONE;
                    SH_EN     <= 1'b0;
                    OUT_VALID <= 1'b1;
                    OUT_Z     <= partial_r | SH_Z;
                    OUT_ERR   <= 1'b0;
                    OUT_TAG   <= tag_r;
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    SH_EN     <= 1'b0;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Self-checking bench for shift_issue_ctrl: behavioural shifter model on SH_*,
// transaction-level reference model with per-cycle compare, directed cases and
// randomized traffic.
module tb_shift_issue_ctrl;
    localparam int TAG_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             IN_VALID, IN_READY;
    logic [2:0]       IN_OP;
    logic [31:0]      IN_X;
    logic [4:0]       IN_S;
    logic [TAG_W-1:0] IN_TAG;
    logic [31:0]      SH_X, SH_Z;
    logic [4:0]       SH_S;
    logic             SH_LEFT, SH_LOG, SH_EN;
    logic             OUT_VALID, OUT_READY;
    logic [31:0]      OUT_Z;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    shift_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
        .IN_X(IN_X), .IN_S(IN_S), .IN_TAG(IN_TAG),
        .SH_X(SH_X), .SH_S(SH_S), .SH_LEFT(SH_LEFT), .SH_LOG(SH_LOG),
        .SH_EN(SH_EN), .SH_Z(SH_Z),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_Z(OUT_Z),
        .OUT_TAG(OUT_TAG), .OUT_ERR(OUT_ERR)
    );

    always #5 CLK = ~CLK;

    // Shifter stand-in: garbage whenever it is not enabled, so off-cycle sampling shows up.
    logic signed [31:0] sx;
    always_comb begin
        sx = SH_X;
        if (!SH_EN)       SH_Z = 32'hDEAD_BEEF;
        else if (SH_LEFT) SH_Z = SH_X << SH_S;
        else if (SH_LOG)  SH_Z = SH_X >> SH_S;
        else              SH_Z = sx >>> SH_S;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {err, z} from the operation's definition.
    function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] x, input logic [4:0] s);
        logic [63:0]        d;
        logic signed [31:0] xs;
        logic [31:0]        r;
        d  = {x, x};
        xs = x;
        case (op)
            3'd0: return {1'b0, x << s};
            3'd1: return {1'b0, x >> s};
            3'd2: begin r = xs >>> s; return {1'b0, r}; end
`ifdef SHIFT_ROTATE_EN
            3'd3: begin d = d << s; return {1'b0, d[63:32]}; end
            3'd4: begin d = d >> s; return {1'b0, d[31:0]}; end
`endif
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [4:0] s);
        logic [32:0] r;
        r = ref_op(op, 32'd0, s);
        if (r[32]) return 1;
        if ((op == 3'd3 || op == 3'd4) && s != 5'd0) return 3;
        return 2;
    endfunction

    // Transaction-level model state.
    logic             m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    logic [31:0]      m_z = 32'd0;
    logic [TAG_W-1:0] m_tag = '0;
    int               m_cnt = 0;
    logic             sv;

    // One clock of stimulus with full output comparison against the model.
    task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] x,
                        input logic [4:0] s, input logic [TAG_W-1:0] tag, input logic ordy);
        logic        exp_rdy, acc;
        logic [32:0] r;
        @(negedge CLK);
        sv = OUT_VALID;
        chk("out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
        chk("sh_en", {31'd0, SH_EN}, {31'd0, m_busy && !m_valid});
        if (m_valid) begin
            chk("out_z", OUT_Z, m_z);
            chk("out_tag", {28'd0, OUT_TAG}, {28'd0, m_tag});
            chk("out_err", {31'd0, OUT_ERR}, {31'd0, m_err});
        end
        IN_VALID = iv; IN_OP = op; IN_X = x; IN_S = s; IN_TAG = tag; OUT_READY = ordy;
        #1;
        exp_rdy = !m_busy || (m_valid && ordy);
        chk("in_ready", {31'd0, IN_READY}, {31'd0, exp_rdy});
        acc = iv && exp_rdy;
        if (m_valid) begin
            if (ordy) begin m_valid = 1'b0; m_busy = 1'b0; end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1'b1;
        end
        if (acc) begin
            r       = ref_op(op, x, s);
            m_z     = r[31:0];
            m_err   = r[32];
            m_tag   = tag;
            m_cnt   = ref_lat(op, s) - 1;
            m_busy  = 1'b1;
            m_valid = (m_cnt == 0);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 99;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b0);
            if (sv) begin lat = k; break; end
        end
    endtask

    // Directed request from idle: literal result, error, tag and latency.
    task automatic direct(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [4:0] s, input logic [TAG_W-1:0] tag,
                          input logic [31:0] ez, input logic eerr, input int elat);
        int lat;
        step(1'b1, op, x, s, tag, 1'b0);
        wait_valid(lat);
        chk({name, "_lat"}, lat, elat);
        chk({name, "_z"}, OUT_Z, ez);
        chk({name, "_err"}, {31'd0, OUT_ERR}, {31'd0, eerr});
        chk({name, "_tag"}, {28'd0, OUT_TAG}, {28'd0, tag});
        step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({name, "_z"}, OUT_Z, 32'd0);
        chk({name, "_tag"}, {28'd0, OUT_TAG}, 32'd0);
        chk({name, "_err"}, {31'd0, OUT_ERR}, 32'd0);
        chk({name, "_sh"}, {SH_X[26:0], SH_S}, 32'd0);
        chk({name, "_shx"}, SH_X, 32'd0);
        chk({name, "_shctl"}, {29'd0, SH_EN, SH_LEFT, SH_LOG}, 32'd0);
        chk({name, "_ready"}, {31'd0, IN_READY}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        RST_N = 1'b0; IN_VALID = 1'b0; IN_OP = 3'd0; IN_X = 32'd0; IN_S = 5'd0;
        IN_TAG = '0; OUT_READY = 1'b0;

        // Model pins against hand-computed values.
        chk("pin_sll", ref_op(3'd0, 32'h0000_00F1, 5'd4), 32'h0000_0F10);
        chk("pin_sra", ref_op(3'd2, 32'h8000_0010, 5'd4), 32'hF800_0001);
        chk("pin_srl", ref_op(3'd1, 32'h8000_0010, 5'd4), 32'h0800_0001);
`ifdef SHIFT_ROTATE_EN
        chk("pin_ror", ref_op(3'd4, 32'h1234_5678, 5'd8), 32'h7812_3456);
`endif

        #3;
        chk_reset_outputs("rst_init");
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;

        direct("sll", 3'd0, 32'h0000_00F1, 5'd4, 4'd3, 32'h0000_0F10, 1'b0, 2);
        direct("sra", 3'd2, 32'h8000_0010, 5'd4, 4'd6, 32'hF800_0001, 1'b0, 2);
        direct("srl", 3'd1, 32'h8000_0010, 5'd4, 4'd7, 32'h0800_0001, 1'b0, 2);
        direct("ill", 3'd7, 32'hFFFF_FFFF, 5'd3, 4'd9, 32'h0000_0000, 1'b1, 1);
`ifdef SHIFT_ROTATE_EN
        direct("ror", 3'd4, 32'h1234_5678, 5'd8, 4'd2, 32'h7812_3456, 1'b0, 3);
        direct("rol0", 3'd3, 32'hCAFE_F00D, 5'd0, 4'd4, 32'hCAFE_F00D, 1'b0, 2);
`else
        direct("ror_off", 3'd4, 32'h1234_5678, 5'd8, 4'd2, 32'h0000_0000, 1'b1, 1);
`endif

        // Backpressure: result held for 5 cycles with a request waiting.
        step(1'b1, 3'd0, 32'h0000_00F1, 5'd4, 4'd1, 1'b0);
        wait_valid(lat);
        chk("bp_lat", lat, 2);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3'd1, 32'h8000_0010, 5'd4, 4'd5, 1'b0);
            chk("bp_z", OUT_Z, 32'h0000_0F10);
            chk("bp_ready", {31'd0, IN_READY}, 32'd0);
        end
        step(1'b1, 3'd1, 32'h8000_0010, 5'd4, 4'd5, 1'b1);
        chk("bp_accept", {31'd0, IN_READY}, 32'd1);
        wait_valid(lat);
        chk("bp2_lat", lat, 2);
        chk("bp2_z", OUT_Z, 32'h0800_0001);
        chk("bp2_tag", {28'd0, OUT_TAG}, 32'd5);
        step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b1);

        // Reset in the middle of a multi-cycle operation.
`ifdef SHIFT_ROTATE_EN
        step(1'b1, 3'd4, 32'h1234_5678, 5'd8, 4'd11, 1'b0);
        step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b0);
`else
        step(1'b1, 3'd0, 32'h1234_5678, 5'd8, 4'd11, 1'b0);
        step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b0);
`endif
        #1 RST_N = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
        @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (3) step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b1);
        direct("sll_post", 3'd0, 32'h0000_00F1, 5'd4, 4'd3, 32'h0000_0F10, 1'b0, 2);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] op;
            logic [4:0] s;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            s  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(($urandom_range(0, 9) < 6), op, $urandom, s, 4'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        repeat (6) step(1'b0, 3'd0, 32'd0, 5'd0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
